// File: rtl/sym_vn_rank_pkg.sv
// sym_vn_rank_pkg: shared geometry helpers and load FSM states for the VN rank LUT (SYM_VN_RANK_WR_FWD_EN selects write-first reads).
package sym_vn_rank_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} ld_state_t;

    function automatic int frm_w(int frames);
        return $clog2(frames);
    endfunction

    function automatic int page_w(int entry_addr, int frames);
        return entry_addr - $clog2(frames);
    endfunction

    function automatic int bank_w(int banks);
        return $clog2(banks);
    endfunction

    localparam int FRM_W    = frm_w(2);
    localparam int PAGE_W   = page_w(5, 2);
    localparam int BANK_W   = bank_w(2);
    localparam int PAGE_NUM = 2 ** PAGE_W;

endpackage

// File: rtl/sym_vn_bank_mem.sv
// sym_vn_bank_mem: one LUT bank, one write port, PORT_NUM registered read ports (SYM_VN_RANK_WR_FWD_EN selects write-first).
module sym_vn_bank_mem import sym_vn_rank_pkg::*; #(
    parameter int QUAN_SIZE  = 3,
    parameter int ENTRY_ADDR = 5,
    parameter int PORT_NUM   = 4
) (
    input  logic                            sys_clk,
    input  logic                            wr_en,
    input  logic [ENTRY_ADDR-1:0]           wr_addr,
    input  logic [QUAN_SIZE-1:0]            wr_data,
    input  logic [PORT_NUM-1:0]             rd_en,
    input  logic [PORT_NUM*ENTRY_ADDR-1:0]  rd_addr,
    output logic [PORT_NUM*QUAN_SIZE-1:0]   rd_data
);

    logic [QUAN_SIZE-1:0] mem [2**ENTRY_ADDR];
    logic [QUAN_SIZE-1:0] q   [PORT_NUM];

    always_ff @(posedge sys_clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        for (int p = 0; p < PORT_NUM; p++)
            if (rd_en[p])
`ifdef SYM_VN_RANK_WR_FWD_EN
                q[p] <= (wr_en && wr_addr == rd_addr[p*ENTRY_ADDR +: ENTRY_ADDR]) ? wr_data
                                                                                  : mem[rd_addr[p*ENTRY_ADDR +: ENTRY_ADDR]];
`else
                q[p] <= mem[rd_addr[p*ENTRY_ADDR +: ENTRY_ADDR]];
`endif
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < PORT_NUM; p++)
            rd_data[p*QUAN_SIZE +: QUAN_SIZE] = q[p];
    end

endmodule

// File: rtl/sym_vn_rank_pipe.sv
// sym_vn_rank_pipe: multi-bank, multi-frame VN rank LUT with a streaming frame-reload engine (SYM_VN_RANK_WR_FWD_EN selects write-first reads).
module sym_vn_rank_pipe import sym_vn_rank_pkg::*; #(
    parameter int QUAN_SIZE       = 3,
    parameter int ENTRY_ADDR      = 5,
    parameter int MULTI_FRAME_NUM = 2,
    parameter int BANK_NUM        = 2,
    parameter int PORT_NUM        = 4,
    localparam int FRM_W          = frm_w(MULTI_FRAME_NUM),
    localparam int PAGE_W         = page_w(ENTRY_ADDR, MULTI_FRAME_NUM),
    localparam int BANK_W         = bank_w(BANK_NUM)
) (
    input  logic                          sys_clk,
    input  logic                          rstn,
    input  logic [PORT_NUM-1:0]           rd_en,
    input  logic [PORT_NUM*BANK_W-1:0]    rd_bank,
    input  logic [PORT_NUM*PAGE_W-1:0]    rd_page,
    input  logic [PORT_NUM*FRM_W-1:0]     rd_frame,
    output logic [PORT_NUM*QUAN_SIZE-1:0] lut_data,
    output logic [PORT_NUM-1:0]           lut_valid,
    input  logic                          load_start,
    input  logic [FRM_W-1:0]              load_frame,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [BANK_NUM*QUAN_SIZE-1:0] load_data,
    output logic                          load_busy,
    output logic                          load_done
);

    ld_state_t                          state_q, state_d;
    logic [PAGE_W-1:0]                  page_cnt;
    logic [FRM_W-1:0]                   frame_q;
    logic                               fire, wr_en;
    logic [PORT_NUM*ENTRY_ADDR-1:0]     rd_addr;
    logic [PORT_NUM-1:0]                oob, zero_q;
    logic [BANK_W-1:0]                  bank_q [PORT_NUM];
    logic [PORT_NUM*QUAN_SIZE-1:0]      bank_rd [BANK_NUM];

    always_comb begin
        load_ready = state_q == LOAD;
        load_busy  = state_q == LOAD;
        load_done  = state_q == DONE;
        fire       = load_ready && load_valid;
        wr_en      = fire && rstn;
        state_d    = (state_q == IDLE && load_start) ? LOAD :
                     (fire && &page_cnt)             ? DONE :
                     (state_q == DONE)               ? IDLE : state_q;
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            page_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && load_start) begin
                frame_q  <= load_frame;
                page_cnt <= '0;
            end else if (fire)
                page_cnt <= page_cnt + 1'b1;
        end
    end

    // Bank select is widened by one bit so BANK_NUM itself is representable in the compare.
    always_comb begin
        rd_addr = '0;
        oob     = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            rd_addr[p*ENTRY_ADDR +: ENTRY_ADDR] = {rd_frame[p*FRM_W +: FRM_W], rd_page[p*PAGE_W +: PAGE_W]};
            oob[p] = {1'b0, rd_bank[p*BANK_W +: BANK_W]} >= (BANK_W+1)'(BANK_NUM);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            lut_valid <= '0;
            zero_q    <= '1;
        end else begin
            lut_valid <= rd_en;
            for (int p = 0; p < PORT_NUM; p++)
                if (rd_en[p]) begin
                    zero_q[p] <= oob[p];
                    bank_q[p] <= rd_bank[p*BANK_W +: BANK_W];
                end
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        sym_vn_bank_mem #(
            .QUAN_SIZE (QUAN_SIZE),
            .ENTRY_ADDR(ENTRY_ADDR),
            .PORT_NUM  (PORT_NUM)
        ) u_mem (
            .sys_clk(sys_clk),
            .wr_en  (wr_en),
            .wr_addr({frame_q, page_cnt}),
            .wr_data(load_data[b*QUAN_SIZE +: QUAN_SIZE]),
            .rd_en  (rd_en),
            .rd_addr(rd_addr),
            .rd_data(bank_rd[b])
        );
    end

    // Bank registers hold while rd_en is low, so the muxed output holds too.
    always_comb begin
        lut_data = '0;
        for (int p = 0; p < PORT_NUM; p++)
            lut_data[p*QUAN_SIZE +: QUAN_SIZE] = zero_q[p] ? '0 : bank_rd[bank_q[p]][p*QUAN_SIZE +: QUAN_SIZE];
    end

endmodule

// File: tb/tb_sym_vn_rank_pipe.sv
// tb_sym_vn_rank_pipe: randomized bench for sym_vn_rank_pipe against an array-based reference of the LUT and load stream.
module tb_sym_vn_rank_pipe;

    localparam int Q = 3, EA = 5, MF = 2, BN = 2, PN = 4;
    localparam int FW = $clog2(MF), PW = EA - FW, BW = $clog2(BN), PAGES = 2 ** PW;
    localparam int BN3 = 3, PN3 = 6, BW3 = 2;

    logic sys_clk = 0;
    logic rstn = 0;
    always #5 sys_clk = ~sys_clk;

    logic [PN-1:0]    rd_en = '0;
    logic [PN*BW-1:0] rd_bank = '0;
    logic [PN*PW-1:0] rd_page = '0;
    logic [PN*FW-1:0] rd_frame = '0;
    logic [PN*Q-1:0]  lut_data;
    logic [PN-1:0]    lut_valid;
    logic             load_start = 0, load_valid = 0;
    logic [FW-1:0]    load_frame = '0;
    logic [BN*Q-1:0]  load_data = '0;
    logic             load_ready, load_busy, load_done;

    sym_vn_rank_pipe u_dut (
        .sys_clk(sys_clk), .rstn(rstn), .rd_en(rd_en), .rd_bank(rd_bank), .rd_page(rd_page),
        .rd_frame(rd_frame), .lut_data(lut_data), .lut_valid(lut_valid), .load_start(load_start),
        .load_frame(load_frame), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_busy(load_busy), .load_done(load_done)
    );

    logic [PN3-1:0]     r3_en = '0;
    logic [PN3*BW3-1:0] r3_bank = '0;
    logic [PN3*PW-1:0]  r3_page = '0;
    logic [PN3*FW-1:0]  r3_frame = '0;
    logic [PN3*Q-1:0]   d3;
    logic [PN3-1:0]     v3;
    logic               rdy3, busy3, done3;

    sym_vn_rank_pipe #(.BANK_NUM(BN3), .PORT_NUM(PN3)) u_dut3 (
        .sys_clk(sys_clk), .rstn(rstn), .rd_en(r3_en), .rd_bank(r3_bank), .rd_page(r3_page),
        .rd_frame(r3_frame), .lut_data(d3), .lut_valid(v3), .load_start(1'b0),
        .load_frame(1'b0), .load_valid(1'b0), .load_ready(rdy3),
        .load_data('0), .load_busy(busy3), .load_done(done3)
    );

    logic [Q-1:0] mem_m [BN][2**EA];
    bit           known [BN][2**EA];
    int           exp_d [PN];
    bit           exp_k [PN];
    bit           exp_v [PN];
    bit           m_load, m_done;
    int           m_frame, m_page;
    int           checks = 0, errors = 0, done_seen = 0, busy_seen = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit fire;
        int b, a, wa;
        fire = m_load && load_valid && rstn;
        wa = m_frame * PAGES + m_page;
        for (int p = 0; p < PN; p++) begin
            if (!rstn) begin
                exp_v[p] = 0; exp_d[p] = 0; exp_k[p] = 1;
            end else begin
                exp_v[p] = rd_en[p];
                if (rd_en[p]) begin
                    b = int'(rd_bank[p*BW +: BW]);
                    a = int'(rd_frame[p*FW +: FW]) * PAGES + int'(rd_page[p*PW +: PW]);
                    if (b >= BN) begin
                        exp_d[p] = 0; exp_k[p] = 1;
                    end else begin
                        exp_d[p] = mem_m[b][a]; exp_k[p] = known[b][a];
`ifdef SYM_VN_RANK_WR_FWD_EN
                        if (fire && a == wa) begin
                            exp_d[p] = load_data[b*Q +: Q]; exp_k[p] = 1;
                        end
`endif
                    end
                end
            end
        end
        if (fire)
            for (int k = 0; k < BN; k++) begin
                mem_m[k][wa] = load_data[k*Q +: Q];
                known[k][wa] = 1;
            end
        if (!rstn) begin
            m_load = 0; m_done = 0;
        end else if (m_done)
            m_done = 0;
        else if (m_load) begin
            if (fire && ++m_page == PAGES) begin
                m_load = 0; m_done = 1;
            end
        end else if (load_start) begin
            m_load = 1; m_frame = load_frame; m_page = 0;
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        for (int p = 0; p < PN; p++) begin
            check($sformatf("valid%0d", p), lut_valid[p], exp_v[p]);
            if (exp_k[p]) check($sformatf("data%0d", p), lut_data[p*Q +: Q], exp_d[p]);
        end
        check("ready", load_ready, m_load);
        check("busy", load_busy, m_load);
        check("done", load_done, m_done);
        done_seen += load_done;
        busy_seen += load_busy;
    endtask

    task automatic rand_reads(int frm);
        for (int p = 0; p < PN; p++) begin
            rd_en[p] = 1'($urandom);
            rd_bank[p*BW +: BW] = BW'($urandom_range(0, BN-1));
            rd_page[p*PW +: PW] = PW'($urandom);
            rd_frame[p*FW +: FW] = frm < 0 ? FW'($urandom) : FW'(frm);
        end
    endtask

    task automatic start_load(int f);
        load_start = 1; load_frame = FW'(f);
        tick();
        load_start = 0;
    endtask

    initial begin
        tick(); tick();
        rstn = 1;
        tick();

        // 1: pattern load of frame 0, then a directed read
        done_seen = 0;
        start_load(0);
        for (int i = 0; i < PAGES; i++) begin
            load_valid = 1; load_data = {3'(7 - i % 8), 3'(i % 8)};
            rand_reads(-1);
            tick();
        end
        load_valid = 0; rd_en = '0;
        tick();
        check("t1_done_cnt", done_seen, 1);
        rd_en = 4'b0100; rd_bank[2*BW +: BW] = 1; rd_frame[2*FW +: FW] = 0; rd_page[2*PW +: PW] = 5;
        tick();
        check("t1_rd", lut_data[2*Q +: Q], 2);
        check("t1_vld", lut_valid[2], 1);

        // 2: load frame 1 while all ports stream reads from frame 0
        start_load(1);
        for (int i = 0; i < PAGES + 3; i++) begin
            load_valid = i < PAGES; load_data = BN*Q'($urandom);
            rand_reads(0); rd_en = '1;
            tick();
        end

        // 3: alternating load_valid
        done_seen = 0; busy_seen = 0;
        load_valid = 0;
        start_load(0);
        for (int c = 0; c < 4 * PAGES && !m_done; c++) begin
            load_valid = (c % 2) == 0; load_data = BN*Q'($urandom);
            rand_reads(-1);
            tick();
        end
        load_valid = 0;
        tick();
        check("t3_busy_cycles", busy_seen, 2 * PAGES - 1);
        check("t3_done_cnt", done_seen, 1);

        // 4: reset after ten accepted beats of frame 1
        done_seen = 0;
        start_load(1);
        for (int i = 0; i < 10; i++) begin
            load_valid = 1; load_data = BN*Q'($urandom);
            rand_reads(-1);
            tick();
        end
        load_valid = 0; rstn = 0; rand_reads(-1);
        tick();
        check("t4_rst_data", lut_data, 0);
        check("t4_rst_valid", lut_valid, 0);
        rstn = 1; rd_en = '0;
        for (int pg = 0; pg < PAGES; pg++)
            for (int b = 0; b < BN; b++) begin
                rd_en = 4'b0001; rd_bank[0 +: BW] = BW'(b); rd_frame[0 +: FW] = 1; rd_page[0 +: PW] = PW'(pg);
                tick();
            end
        check("t4_done_cnt", done_seen, 0);

        // 5: read of the entry being written
        rd_en = '0;
        for (int pass = 0; pass < 2; pass++) begin
            start_load(0);
            for (int i = 0; i < PAGES; i++) begin
                load_valid = 1;
                load_data = BN*Q'($urandom);
                if (i == 3) load_data[0 +: Q] = pass == 0 ? 3'd1 : 3'd6;
                rd_en = '0;
                if (pass == 1 && i == 3) begin
                    rd_en = 4'b0001; rd_bank[0 +: BW] = 0; rd_frame[0 +: FW] = 0; rd_page[0 +: PW] = 3;
                end
                tick();
`ifdef SYM_VN_RANK_WR_FWD_EN
                if (pass == 1 && i == 3) check("t5_rdw", lut_data[0 +: Q], 6);
`else
                if (pass == 1 && i == 3) check("t5_rdw", lut_data[0 +: Q], 1);
`endif
            end
            load_valid = 0; rd_en = '0;
            tick();
        end

        // random soak
        for (int c = 0; c < 400; c++) begin
            rstn = $urandom_range(0, 63) != 0;
            load_start = $urandom_range(0, 7) == 0;
            load_frame = FW'($urandom);
            load_valid = 1'($urandom);
            load_data = BN*Q'($urandom);
            rand_reads(-1);
            tick();
        end
        rstn = 1; load_start = 0; load_valid = 0; rd_en = '0;
        tick();

        // 6: out-of-range bank on a three-bank, six-port build
        check("t6_rst_data", d3, 0);
        r3_en = 6'b100000; r3_bank[5*BW3 +: BW3] = 2'd3;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("t6_oob_data", d3[5*Q +: Q], 0);
        check("t6_oob_valid", v3[5], 1);
        check("t6_idle_valid", v3[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
